// File: rtl/shifter_pkg.sv
// Shared types and constants for the shifter family (barrel and sequential).
package shifter_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} seq_shift_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational logical shifter, left/right by 0..WIDTH-1 with zero fill.
module barrel_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shift_amt,
    input  logic               dir,
    output logic [WIDTH-1:0]   data_out
);

    always_comb begin
        data_out = (dir == DIR_RIGHT) ? (data_in >> shift_amt) : (data_in << shift_amt);
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle logical shifter: one bit position per clock, valid/ready on both sides.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shift_amt,
    input  logic               dir,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_out
);

    seq_shift_state_t   state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= DIR_LEFT;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            out_valid_q <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = data_in;
                    cnt_d   = shift_amt;
                    dir_d   = dir;
                    state_d = (shift_amt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                data_d = (dir_q == DIR_RIGHT) ? (data_q >> 1) : (data_q << 1);
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready decodes straight from the state register; no input feeds it.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = out_valid_q;
        data_out  = data_q;
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and randomised checks of seq_shifter against hand values and barrel_shifter.
module tb_seq_shifter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned SHAMT_W = 5;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shift_amt;
    logic               dir;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_out;

    logic [WIDTH-1:0]   r_d;
    logic [SHAMT_W-1:0] r_a;
    logic               r_dir;
    logic [WIDTH-1:0]   r_out;

    int checks   = 0;
    int failures = 0;

    seq_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .dir       (dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    barrel_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) golden (
        .data_in   (r_d),
        .shift_amt (r_a),
        .dir       (r_dir),
        .data_out  (r_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; inputs are scrambled right after accept.
    task automatic do_op(input string tag, input logic [31:0] d, input logic [4:0] a,
                         input logic dr, input logic [31:0] exp, input int stall);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        data_in   = d;
        shift_amt = a;
        dir       = dr;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        data_in   = $urandom;
        shift_amt = 5'($urandom);
        dir       = ~dr;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(a) + 32'd1);
        for (int i = 0; i < stall; i++) tick();
        check({tag, "_data"}, data_out, exp);
        check({tag, "_hold"}, 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release"}, {30'b0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        logic [31:0] exp;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        shift_amt = '0;
        dir       = 1'b0;
        out_ready = 1'b0;
        r_d       = '0;
        r_a       = '0;
        r_dir     = 1'b0;

        tick();
        tick();
        check("rst_low", {in_ready, out_valid, 30'b0} | 32'(data_out), 32'h8000_0000);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("idle_flags", {30'b0, in_ready, out_valid}, 32'b10);
        check("idle_data", data_out, 32'h0);

        do_op("left4", 32'hA5A5_A5A5, 5'd4, 1'b0, 32'h5A5A_5A50, 0);
        do_op("right0", 32'hA5A5_A5A5, 5'd0, 1'b1, 32'hA5A5_A5A5, 0);
        do_op("right31", 32'hA5A5_A5A5, 5'd31, 1'b1, 32'h0000_0001, 0);

        // Back-pressure with a competing request that must be dropped.
        data_in   = 32'h8000_0001;
        shift_amt = 5'd1;
        dir       = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                data_in   = 32'h1234_5678;
                shift_amt = 5'd0;
                in_valid  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data", data_out, 32'h4000_0000);
            check("bp_not_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", {30'b0, in_ready, out_valid}, 32'b10);
        tick();
        tick();
        check("bp_no_queue", {30'b0, in_ready, out_valid}, 32'b10);

        // Reset in the middle of a 20-step shift.
        data_in   = 32'hFFFF_FFFF;
        shift_amt = 5'd20;
        dir       = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {30'b0, in_ready, out_valid}, 32'b10);
        check("midrst_data", data_out, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("midrst_discard", {30'b0, in_ready, out_valid}, 32'b10);
        do_op("post_rst", 32'h0000_FFFF, 5'd8, 1'b0, 32'h00FF_FF00, 0);

        for (int dr = 0; dr < 2; dr++) begin
            for (int a = 0; a < 32; a++) begin
                r_d   = 32'hDEAD_BEEF;
                r_a   = 5'(a);
                r_dir = 1'(dr);
                #1;
                exp = r_out;
                do_op("sweep", r_d, r_a, r_dir, exp, 0);
            end
        end

        for (int n = 0; n < 100; n++) begin
            r_d   = $urandom;
            r_a   = 5'($urandom_range(0, 31));
            r_dir = 1'($urandom_range(0, 1));
            #1;
            exp = r_out;
            do_op("rand", r_d, r_a, r_dir, exp, int'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
